// File: rtl/cordic_pkg.sv
// Shared widths, constants and state encoding for the iterative CORDIC sequencer.
package cordic_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned Z_W    = 34;
    localparam int unsigned ADDR_W = 5;

    // CORDIC gain compensation 1/K in Q2.30, pre-loaded into x
    localparam logic [DATA_W-1:0] K_Q230 = 32'h26DD3B6A;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/cordic_iter_ctrl_rom.sv
// Combinational arctan table: data = round(atan(2^-address) * 2^31), unsigned.
module cordic_iter_ctrl_rom
    import cordic_pkg::*;
(
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = '0;
        case (address)
            5'd0:  data = 32'h6487ED51;
            5'd1:  data = 32'h3B58CE0B;
            5'd2:  data = 32'h1F5B75F9;
            5'd3:  data = 32'h0FEADD4D;
            5'd4:  data = 32'h07FD56EE;
            5'd5:  data = 32'h03FFAAB7;
            5'd6:  data = 32'h01FFF556;
            5'd7:  data = 32'h00FFFEAB;
            5'd8:  data = 32'h007FFFD5;
            5'd9:  data = 32'h003FFFFB;
            5'd10: data = 32'h001FFFFF;
            5'd11: data = 32'h00100000;
            5'd12: data = 32'h00080000;
            5'd13: data = 32'h00040000;
            5'd14: data = 32'h00020000;
            5'd15: data = 32'h00010000;
            5'd16: data = 32'h00008000;
            5'd17: data = 32'h00004000;
            5'd18: data = 32'h00002000;
            5'd19: data = 32'h00001000;
            5'd20: data = 32'h00000800;
            5'd21: data = 32'h00000400;
            5'd22: data = 32'h00000200;
            5'd23: data = 32'h00000100;
            5'd24: data = 32'h00000080;
            5'd25: data = 32'h00000040;
            5'd26: data = 32'h00000020;
            5'd27: data = 32'h00000010;
            5'd28: data = 32'h00000008;
            5'd29: data = 32'h00000004;
            5'd30: data = 32'h00000002;
            5'd31: data = 32'h00000001;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/cordic_iter_ctrl.sv
// Iterative rotation-mode CORDIC sequencer: one micro-rotation per enabled cycle,
// cos/sin of a Q2.30 angle reported with a single-cycle done.
module cordic_iter_ctrl
    import cordic_pkg::*;
#(
    parameter int unsigned ITERATIONS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              start,
    input  logic [DATA_W-1:0] angle,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] cos_out,
    output logic [DATA_W-1:0] sin_out
);

    localparam logic [ADDR_W-1:0] LastIter = ADDR_W'(ITERATIONS - 1);

    state_e                   state_q, state_d;
    logic signed [DATA_W-1:0] x_q, y_q, x_d, y_d, x_sh, y_sh;
    logic signed [Z_W-1:0]    z_q, z_d, atan_ext;
    logic [ADDR_W-1:0]        iter_q;
    logic [ADDR_W-1:0]        rom_addr;
    logic [DATA_W-1:0]        rom_data;
    logic                     load;

    assign rom_addr = iter_q;

    cordic_iter_ctrl_rom u_rom (
        .address (rom_addr),
        .data    (rom_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else if (clk_en) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (iter_q == LastIter) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign load = (state_q == StIdle) && start;

    // Direction comes from the sign of the residual angle; all terms use old values.
    always_comb begin
        x_sh     = x_q >>> iter_q;
        y_sh     = y_q >>> iter_q;
        atan_ext = $signed({2'b00, rom_data});
        if (!z_q[Z_W-1]) begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - atan_ext;
        end else begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + atan_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            iter_q <= '0;
        end else if (clk_en) begin
            if (load) begin
                x_q    <= K_Q230;
                y_q    <= '0;
                z_q    <= {angle[DATA_W-1], angle, 1'b0};
                iter_q <= '0;
            end else if (state_q == StRun) begin
                x_q    <= x_d;
                y_q    <= y_d;
                z_q    <= z_d;
                iter_q <= iter_q + 1'b1;
            end
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);
    assign cos_out = x_q;
    assign sin_out = y_q;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Bench for cordic_iter_ctrl: table vectors, hand-written corner sequences and random
// angles checked against an integer CORDIC model and real-valued cos/sin.
module tb_cordic_iter_ctrl;

    localparam int     ITER  = 16;
    localparam longint TOL   = 65536;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic        start;
    logic [31:0] angle;
    logic        busy;
    logic        done;
    logic [31:0] cos_out;
    logic [31:0] sin_out;

    int n_checks = 0;
    int n_fail   = 0;

    longint atan_tab [ITER];

    typedef struct {
        logic [31:0] ang;
        int          stall_at;
        int          stall_len;
        bit          poke;
        int          lat;
        longint      cos_e;
        longint      sin_e;
    } vec_t;

    vec_t vecs [4];

    cordic_iter_ctrl #(.ITERATIONS(ITER)) dut (
        .clk     (clk),
        .reset   (reset),
        .clk_en  (clk_en),
        .start   (start),
        .angle   (angle),
        .busy    (busy),
        .done    (done),
        .cos_out (cos_out),
        .sin_out (sin_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic chk_tol(input string name, input logic signed [63:0] act, input longint exp);
        longint diff;
        n_checks++;
        diff = act - exp;
        if (diff < 0) diff = -diff;
        if ($isunknown(act) || diff > TOL) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d +/- %0d", name, act, exp, TOL);
        end
    endtask

    // Plain iterative CORDIC on integers with its own arctan table.
    function automatic void model(input logic [31:0] a, output logic [31:0] xo,
                                  output logic [31:0] yo);
        logic signed [31:0] x, y, xs, ys;
        logic signed [33:0] z, t;
        x = 32'sh26DD3B6A;
        y = '0;
        z = $signed({a[31], a, 1'b0});
        for (int i = 0; i < ITER; i++) begin
            xs = x >>> i;
            ys = y >>> i;
            t  = 34'(atan_tab[i]);
            if (z >= 0) begin
                x = x - ys;
                y = y + xs;
                z = z - t;
            end else begin
                x = x + ys;
                y = y - xs;
                z = z + t;
            end
        end
        xo = x;
        yo = y;
    endfunction

    task automatic run_op(input logic [31:0] a, input int stall_at, input int stall_len,
                          input bit poke, input int exp_lat, input bit use_tol,
                          input longint cos_e, input longint sin_e);
        int          lat;
        int          exp_iter;
        bit          en_prev;
        logic [31:0] mx, my;
        model(a, mx, my);
        angle = a;
        start = 1'b1;
        tick();
        start    = 1'b0;
        lat      = 1;
        exp_iter = 0;
        chk("busy_after_start", busy, 1);
        while (!done && lat < 80) begin
            chk("rom_addr", dut.rom_addr, exp_iter);
            if (lat == stall_at) clk_en = 1'b0;
            if (lat == stall_at + stall_len) clk_en = 1'b1;
            start   = poke && (lat == 3 || lat == stall_at + 1);
            en_prev = clk_en;
            tick();
            start = 1'b0;
            lat++;
            if (en_prev) exp_iter++;
        end
        clk_en = 1'b1;
        chk("done_latency", lat, exp_lat);
        chk("done_high", done, 1);
        chk("cos_exact", $signed(cos_out), $signed(mx));
        chk("sin_exact", $signed(sin_out), $signed(my));
        if (use_tol) begin
            chk_tol("cos_value", $signed(cos_out), cos_e);
            chk_tol("sin_value", $signed(sin_out), sin_e);
        end
        tick();
        chk("done_single_pulse", done, 0);
        chk("busy_back_idle", busy, 0);
        chk("cos_hold", $signed(cos_out), $signed(mx));
    endtask

    initial begin
        real         p;
        int          lat;
        logic [31:0] mx, my;

        reset  = 1'b1;
        clk_en = 1'b1;
        start  = 1'b0;
        angle  = '0;

        p = 1.0;
        for (int i = 0; i < ITER; i++) begin
            atan_tab[i] = longint'($atan(p) * 2147483648.0);
            p = p / 2.0;
        end

        vecs[0] = '{32'h00000000, 0, 0, 1'b0, 17, 1073741824, 0};
        vecs[1] = '{32'h20000000, 0, 0, 1'b0, 17, 942297101, 514779252};
        vecs[2] = '{32'hE0000000, 0, 0, 1'b0, 17, 942297101, -514779252};
        vecs[3] = '{32'h20000000, 6, 5, 1'b1, 22, 942297101, 514779252};

        tick();
        tick();
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_cos", cos_out, 0);
        chk("reset_sin", sin_out, 0);
        chk("reset_iter", dut.rom_addr, 0);
        reset = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // Abort mid-run: reset sampled on E5
        angle = 32'h20000000;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("midrun_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_cos", cos_out, 0);
        chk("abort_sin", sin_out, 0);
        chk("abort_iter", dut.rom_addr, 0);

        foreach (vecs[v]) begin
            run_op(vecs[v].ang, vecs[v].stall_at, vecs[v].stall_len, vecs[v].poke,
                   vecs[v].lat, 1'b1, vecs[v].cos_e, vecs[v].sin_e);
        end

        // start held high straight through the done cycle
        model(32'h20000000, mx, my);
        angle = 32'h20000000;
        start = 1'b1;
        tick();
        lat = 1;
        while (!done && lat < 80) begin
            tick();
            lat++;
        end
        chk("held_first_latency", lat, 17);
        tick();
        chk("held_ignored_in_done", busy, 0);
        chk("held_done_pulse", done, 0);
        tick();
        chk("held_accepted_in_idle", busy, 1);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 80) begin
            tick();
            lat++;
        end
        chk("held_second_latency", lat, 17);
        chk("held_cos", $signed(cos_out), $signed(mx));
        chk("held_sin", $signed(sin_out), $signed(my));
        tick();

        for (int k = 0; k < 10; k++) begin
            longint      ai;
            logic [31:0] a;
            int          sa, sl;
            bit          inr;
            real         ar;
            inr = (k < 7);
            if (inr) begin
                ai = longint'($urandom_range(32'd3736000000, 32'd0)) - 64'd1868000000;
                a  = ai[31:0];
            end else begin
                a = $urandom;
            end
            sa = $urandom_range(2, 14);
            sl = $urandom_range(0, 3);
            ar = $itor($signed(a)) / 1073741824.0;
            run_op(a, sa, sl, k[0], 17 + sl, inr, longint'($cos(ar) * 1073741824.0),
                   longint'($sin(ar) * 1073741824.0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
